// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - issue/execute side signals of the multiply/divide unit
// master drives operands and control; slave is the unit and returns HI/LO and status.
interface ex_muldiv_unit_if #(parameter int DATA_W = 32);
  logic              valid_muldiv_i;
  logic [2:0]        op_muldiv_i;
  logic [DATA_W-1:0] rs_data_muldiv_i;
  logic [DATA_W-1:0] rt_data_muldiv_i;
  logic              rd_hilo_muldiv_i;
  logic              flush_muldiv_i;
  logic [DATA_W-1:0] hi_muldiv_o;
  logic [DATA_W-1:0] lo_muldiv_o;
  logic              busy_muldiv_o;
  logic              done_muldiv_o;
  logic              stall_muldiv_o;

  modport master (
    output valid_muldiv_i, op_muldiv_i, rs_data_muldiv_i, rt_data_muldiv_i,
           rd_hilo_muldiv_i, flush_muldiv_i,
    input  hi_muldiv_o, lo_muldiv_o, busy_muldiv_o, done_muldiv_o, stall_muldiv_o
  );

  modport slave (
    input  valid_muldiv_i, op_muldiv_i, rs_data_muldiv_i, rt_data_muldiv_i,
           rd_hilo_muldiv_i, flush_muldiv_i,
    output hi_muldiv_o, lo_muldiv_o, busy_muldiv_o, done_muldiv_o, stall_muldiv_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative multiply/divide unit owning HI/LO
// Magnitudes are processed unsigned; sign correction happens once in FIX.
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input logic            clk,
  input logic            reset,
  ex_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a, b, rs_raw, hi, lo;
  logic [2*DATA_W-1:0] acc;
  logic                neg_a, neg_b, sgn_op, div_op;
  logic                busy, done, accept, start, mt_hi, mt_lo, last_iter;
  logic [DATA_W-1:0]   abs_rs, abs_rt;
  logic [DATA_W:0]     mul_sum, rem_sh, rem_diff;
  logic                q_bit;
  logic [2*DATA_W-1:0] mul_step, div_step, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic                neg_res;

  assign accept    = (state == IDLE) && bus.valid_muldiv_i && !bus.flush_muldiv_i;
  assign start     = accept && !bus.op_muldiv_i[2];
  assign mt_hi     = accept && (bus.op_muldiv_i == OP_MTHI);
  assign mt_lo     = accept && (bus.op_muldiv_i == OP_MTLO);
  assign last_iter = (cnt == '1);

  // Unsigned ops (op[0] = 1) keep raw operands.
  assign abs_rs = (!bus.op_muldiv_i[0] && bus.rs_data_muldiv_i[DATA_W-1]) ?
                  -bus.rs_data_muldiv_i : bus.rs_data_muldiv_i;
  assign abs_rt = (!bus.op_muldiv_i[0] && bus.rt_data_muldiv_i[DATA_W-1]) ?
                  -bus.rt_data_muldiv_i : bus.rt_data_muldiv_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = bus.op_muldiv_i[1] ? DIV : MUL;
      MUL, DIV: begin
        busy = 1'b1;
        if (bus.flush_muldiv_i) state_nxt = IDLE;
        else if (last_iter)     state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: low half holds the remaining multiplier bits, shifted out LSB first.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, a} : '0);
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign rem_sh   = acc[2*DATA_W-1:DATA_W-1];
  assign rem_diff = rem_sh - {1'b0, b};
  assign q_bit    = (rem_sh >= {1'b0, b});
  assign div_step = {q_bit ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0], acc[DATA_W-2:0], q_bit};

  assign neg_res  = sgn_op && (neg_a ^ neg_b);
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem_fix  = (sgn_op && neg_a) ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      rs_raw <= '0;
      acc    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      sgn_op <= 1'b0;
      div_op <= 1'b0;
    end else begin
      if (start) begin
        a      <= abs_rs;
        b      <= abs_rt;
        rs_raw <= bus.rs_data_muldiv_i;
        neg_a  <= !bus.op_muldiv_i[0] && bus.rs_data_muldiv_i[DATA_W-1];
        neg_b  <= !bus.op_muldiv_i[0] && bus.rt_data_muldiv_i[DATA_W-1];
        sgn_op <= !bus.op_muldiv_i[0];
        div_op <= bus.op_muldiv_i[1];
        cnt    <= '0;
        acc    <= {{DATA_W{1'b0}}, bus.op_muldiv_i[1] ? abs_rs : abs_rt};
      end
      if (mt_hi) hi <= bus.rs_data_muldiv_i;
      if (mt_lo) lo <= bus.rs_data_muldiv_i;
      if (state == MUL || state == DIV) begin
        cnt <= cnt + 1'b1;
        acc <= (state == DIV) ? div_step : mul_step;
      end
      if (state == FIX && !bus.flush_muldiv_i) begin
        if (!div_op) begin
          hi <= prod_fix[2*DATA_W-1:DATA_W];
          lo <= prod_fix[DATA_W-1:0];
        end else if (b == '0) begin
          hi <= rs_raw;
          lo <= '1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
    end
  end

  assign bus.hi_muldiv_o    = hi;
  assign bus.lo_muldiv_o    = lo;
  assign bus.busy_muldiv_o  = busy;
  assign bus.done_muldiv_o  = done;
  assign bus.stall_muldiv_o = busy && ((bus.valid_muldiv_i && (bus.op_muldiv_i < 3'd6))
                                       || bus.rd_hilo_muldiv_i);
endmodule
